// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues memory reads and
// loads the returned word into the instruction register.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         READ_LAT = 1
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic        fetch_start,
  input  logic        branch_en,
  input  logic [7:0]  branch_addr,
  input  logic [15:0] mem_data,
  output logic [7:0]  pc_addr,
  output logic        mem_pc_sel,
  output logic        mem_read,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAP,
    S_DONE
  } state_e;

  localparam logic [1:0] WAIT_LAST =
    (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        pend_q, pend_d;
  logic [7:0]  pend_addr_q, pend_addr_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch_start) state_d = S_REQ;
        if (branch_en) begin
          pc_d   = branch_addr;
          pend_d = 1'b0;
        end
      end
      S_REQ: begin
        cnt_d   = 2'd0;
        state_d = (READ_LAT > 1) ? S_WAIT : S_CAP;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_CAP;
        else cnt_d = cnt_q + 2'd1;
      end
      S_CAP: begin
        ir_d    = mem_data;
        pend_d  = 1'b0;
        state_d = S_DONE;
        if (branch_en)   pc_d = branch_addr;
        else if (pend_q) pc_d = pend_addr_q;
        else             pc_d = pc_q + 8'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Branches outside IDLE/CAPTURE wait for the next PC update.
    if (branch_en && (state_q == S_REQ || state_q == S_WAIT ||
                      state_q == S_DONE)) begin
      pend_d      = 1'b1;
      pend_addr_d = branch_addr;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      pend_q      <= 1'b0;
      pend_addr_q <= 8'h00;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pc_addr    = pc_q;
  assign ir         = ir_q;
  assign mem_read   = (state_q == S_REQ);
  assign mem_pc_sel = (state_q == S_REQ) || (state_q == S_WAIT) ||
                      (state_q == S_CAP);
  assign ir_valid   = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit at read latencies 1 and 3.
// Each DUT has a private memory model with exact read latency.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fs = 1'b0;
  logic        br = 1'b0;
  logic [7:0]  ba = 8'h00;

  logic [15:0] md1, md3;
  logic [7:0]  pc1, pc3;
  logic        sel1, sel3, rd1, rd3, iv1, iv3, bz1, bz3;
  logic [15:0] ir1, ir3;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(8'h00), .READ_LAT(1)) u1 (
    .CLK100MHZ(clk), .RST(rst), .fetch_start(fs),
    .branch_en(br), .branch_addr(ba), .mem_data(md1),
    .pc_addr(pc1), .mem_pc_sel(sel1), .mem_read(rd1),
    .ir(ir1), .ir_valid(iv1), .busy(bz1)
  );

  fetch_unit #(.RESET_PC(8'h00), .READ_LAT(3)) u3 (
    .CLK100MHZ(clk), .RST(rst), .fetch_start(fs),
    .branch_en(br), .branch_addr(ba), .mem_data(md3),
    .pc_addr(pc3), .mem_pc_sel(sel3), .mem_read(rd3),
    .ir(ir3), .ir_valid(iv3), .busy(bz3)
  );

  function automatic logic [15:0] memf(input logic [7:0] a);
    return (a == 8'h00) ? 16'hA5C3 : {a, a ^ 8'h5A};
  endfunction

  // Data is valid for exactly one cycle, READ_LAT edges after the read.
  logic [15:0] p1 = 16'hDEAD;
  logic [15:0] p3 [3] = '{16'hDEAD, 16'hDEAD, 16'hDEAD};

  always @(posedge clk) begin
    p1    <= rd1 ? memf(pc1) : 16'hDEAD;
    p3[0] <= rd3 ? memf(pc3) : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign md1 = p1;
  assign md3 = p3[2];

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int n_rd, n_iv, last;

  initial begin
    #1;
    // Reset then a single fetch at latency 1
    do_reset();
    chk("rst_pc", pc1, 16'h00);
    chk("rst_ir", ir1, 16'h0000);
    chk("rst_busy", bz1, 1'b0);
    chk("rst_rd", rd1, 1'b0);
    chk("rst_iv", iv1, 1'b0);
    chk("rst_sel", sel1, 1'b0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("t1_rd", rd1, 1'b1);
    chk("t1_addr", pc1, 16'h00);
    chk("t1_sel", sel1, 1'b1);
    chk("t1_busy", bz1, 1'b1);
    tick();
    chk("t1_rd_once", rd1, 1'b0);
    chk("t1_iv_early", iv1, 1'b0);
    tick();
    chk("t1_iv", iv1, 1'b1);
    chk("t1_ir", ir1, 16'hA5C3);
    chk("t1_pc", pc1, 16'h01);
    tick();
    chk("t1_iv_off", iv1, 1'b0);
    chk("t1_idle", bz1, 1'b0);
    chk("t1_pc_hold", pc1, 16'h01);

    // Branch to 0xFF in IDLE, fetch, wrap to 0x00
    br = 1'b1; ba = 8'hFF;
    tick();
    br = 1'b0;
    chk("t2_pc_br", pc1, 16'hFF);
    chk("t2_busy", bz1, 1'b0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("t2_rd", rd1, 1'b1);
    chk("t2_addr", pc1, 16'hFF);
    tick();
    tick();
    chk("t2_iv", iv1, 1'b1);
    chk("t2_ir", ir1, memf(8'hFF));
    chk("t2_wrap", pc1, 16'h00);

    // Latency 3: branch during WAIT is deferred to CAPTURE
    do_reset();
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("t3_rd", rd3, 1'b1);
    chk("t3_addr", pc3, 16'h00);
    tick();
    chk("t3_wait_rd", rd3, 1'b0);
    chk("t3_wait_sel", sel3, 1'b1);
    br = 1'b1; ba = 8'h40;
    tick();
    br = 1'b0;
    chk("t3_pc_stable", pc3, 16'h00);
    tick();
    chk("t3_iv_early", iv3, 1'b0);
    chk("t3_pc_stable2", pc3, 16'h00);
    tick();
    chk("t3_iv", iv3, 1'b1);
    chk("t3_ir", ir3, 16'hA5C3);
    chk("t3_pc", pc3, 16'h40);
    tick();
    chk("t3_idle", bz3, 1'b0);

    // Reset during WAIT aborts the fetch
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("t5_addr", pc3, 16'h40);
    tick();
    chk("t5_in_wait", bz3, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", bz3, 1'b0);
    chk("t5_rd", rd3, 1'b0);
    chk("t5_sel", sel3, 1'b0);
    chk("t5_pc", pc3, 16'h00);
    chk("t5_ir", ir3, 16'h0000);
    n_iv = 0;
    for (int i = 0; i < 8; i++) begin
      if (iv3) n_iv++;
      tick();
    end
    chk("t5_no_iv", 16'(n_iv), 16'd0);

    // fetch_start held high: one read every 4 cycles, 0,1,2
    do_reset();
    fs = 1'b1;
    n_rd = 0; n_iv = 0; last = -4;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rd1) begin
        chk("t4_addr", pc1, 16'(n_rd));
        chk("t4_gap", 16'(i - last), 16'd4);
        last = i;
        n_rd++;
      end
      if (iv1) n_iv++;
    end
    fs = 1'b0;
    chk("t4_reads", 16'(n_rd), 16'd3);
    chk("t4_valids", 16'(n_iv), 16'd3);

    // Branch and start together in IDLE
    do_reset();
    fs = 1'b1; br = 1'b1; ba = 8'h22;
    tick();
    fs = 1'b0; br = 1'b0;
    chk("t6_rd", rd1, 1'b1);
    chk("t6_addr", pc1, 16'h22);
    tick();
    tick();
    chk("t6_iv", iv1, 1'b1);
    chk("t6_ir", ir1, memf(8'h22));
    chk("t6_pc", pc1, 16'h23);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the memory block. Holds the 8-bit program counter and drives the PC-side address and read request into the memory block. Captures the returned 16-bit word into the instruction register and hands it to the control unit with a one-cycle valid pulse. Also handles PC increment, wrap-around and branch loads.

## Interface

Parameters:
- `RESET_PC`, default 8'h00: PC value after reset.
- `READ_LAT`, default 1: clocks from the edge that samples `mem_read`=1 to the edge where `mem_data` is valid. Legal range 1..4.

Ports:
- `CLK100MHZ` in 1: the single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `fetch_start` in 1: request one fetch; sampled only in IDLE.
- `branch_en` in 1: load PC from `branch_addr`.
- `branch_addr` in 8: branch target.
- `mem_data` in 16: memory block data output.
- `pc_addr` out 8: current PC, feeds the memory PC address input.
- `mem_pc_sel` out 1: 1 = fetch owns memory; the control unit drives the memory mux select from this.
- `mem_read` out 1: read strobe to memory; 1 only in REQ.
- `ir` out 16: instruction register.
- `ir_valid` out 1: one-cycle pulse, `ir` is newly loaded.
- `busy` out 1: 1 in any state other than IDLE.

## Operation

- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, REQ, WAIT, CAPTURE, DONE.
- IDLE:
  - `fetch_start`=1 → REQ.
- REQ (exactly one cycle):
  - Outputs: `mem_pc_sel`=1, `mem_read`=1.
  - Next state: WAIT if `READ_LAT` > 1, else CAPTURE.
- WAIT:
  - Outputs: `mem_pc_sel`=1, `mem_read`=0.
  - A 2-bit counter runs `READ_LAT`−1 cycles, then → CAPTURE.
- CAPTURE:
  - `ir` <= `mem_data`.
  - `pc` <= `pc`+1, modulo 256 (8'hFF → 8'h00). A pending branch overrides the increment.
  - Next state: DONE.
- DONE (one cycle):
  - `ir_valid`=1, then → IDLE.
- Branch while IDLE: `pc` <= `branch_addr` on that edge.
- Branch while busy:
  - `branch_addr` is latched into a pending register and applied at CAPTURE instead of the increment.
  - A later branch before CAPTURE overwrites the pending one.
  - A branch on the CAPTURE edge itself wins over both the increment and any pending value.
- `fetch_start` and `branch_en` together in IDLE: PC loads the branch target and the fetch proceeds. REQ issues the new address.
- `fetch_start` while busy is ignored, not queued.
- `pc_addr` is stable from REQ through CAPTURE. It changes only on the CAPTURE edge or on an IDLE branch.
- `ir` holds its value until the next CAPTURE.

## Timing

- Reset values:
  - `pc_addr`=`RESET_PC`, `ir`=16'h0000.
  - `ir_valid`=0, `busy`=0, `mem_read`=0, `mem_pc_sel`=0.
  - FSM in IDLE, pending-branch flag cleared.
- Reset asserted in any state aborts the fetch on that edge: all of the above values apply next cycle, and no `ir_valid` is produced.
- Latency, with `fetch_start` sampled at edge E0:
  - REQ occupies cycle E0..E1.
  - `mem_data` is captured at edge E1+`READ_LAT`.
  - `ir_valid` is high for the cycle after that edge.
  - For `READ_LAT`=1: `ir_valid` is high in cycle 3 after E0, and `busy` lasts 3 cycles.
- Back-to-back fetches: the earliest next `fetch_start` is sampled in the cycle following DONE. Throughput is one instruction per `READ_LAT`+3 cycles.

## Test plan

- Reset then `fetch_start` pulse, memory[0x00]=16'hA5C3, `READ_LAT`=1:
  - `mem_read` high exactly one cycle with `pc_addr`=0x00.
  - `ir`=16'hA5C3, with `ir_valid` pulsed one cycle, 3 cycles after start.
  - `pc_addr`=0x01 afterwards.
- `branch_en` with `branch_addr`=0xFF in IDLE, then fetch:
  - REQ drives 0xFF.
  - After CAPTURE, `pc_addr`=0x00 (wrap).
- `branch_en` with `branch_addr`=0x40 during WAIT (`READ_LAT`=3):
  - The fetch completes from the old address.
  - `pc_addr`=0x40, not old+1.
- `fetch_start` held high continuously:
  - Fetches repeat every `READ_LAT`+3 cycles at addresses 0,1,2,….
  - Extra `fetch_start` cycles while busy cause no additional `mem_read` pulses.
- `RST` asserted in WAIT:
  - Next cycle `busy`=0, `mem_read`=0, `pc_addr`=`RESET_PC`, `ir`=0.
  - No `ir_valid` pulse.
- `fetch_start`, `branch_en` and `branch_addr`=0x22 in the same IDLE cycle:
  - REQ issues address 0x22.
  - `pc_addr` ends at 0x23.
